// File: rtl/voice_cmd_sched_if.sv
// Request / driver bus for the voice command scheduler.
// master = requesters + driver side, slave = scheduler.
interface voice_cmd_sched_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    req_valid;
  logic [31:0]   req_code;
  logic [3:0]    req_ack;
  logic          drv_start;
  logic [7:0]    drv_code;
  logic          drv_done;
  logic          voice_busy;
  logic          flush;
  logic [LW-1:0] fifo_level;
  logic          idle;

  modport master (
    output req_valid, req_code, drv_done,
    output voice_busy, flush,
    input  req_ack, drv_start, drv_code,
    input  fifo_level, idle
  );

  modport slave (
    input  req_valid, req_code, drv_done,
    input  voice_busy, flush,
    output req_ack, drv_start, drv_code,
    output fifo_level, idle
  );
endinterface

// File: rtl/voice_cmd_sched.sv
// Round-robin request arbiter, command FIFO and paced
// issue sequencer in front of the one-wire voice driver.
module voice_cmd_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2_500_000
) (
  input logic clk_50m,
  input logic rst_n,
  voice_cmd_sched_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_BWAIT = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] gap_q, gap_d;
  logic [AW-1:0] wp_q, rp_q;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [3:0]    ack_q;
  logic [1:0]    last_q;
  logic          start_q;
  logic [7:0]    code_q;
  logic          b1_q, busy_q;

  logic [3:0] elig;
  logic       gnt_vld;
  logic [1:0] gnt_idx, idx;
  logic       push, pop, go;

  // Requesters just acked are still withdrawing; skip them.
  assign elig = bus.req_valid & ~ack_q;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last_q;
    idx     = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign push = gnt_vld && !bus.flush &&
                (lvl_q < LW'(FIFO_DEPTH));
  assign go   = (state_q == S_IDLE) &&
                (lvl_q != '0) && !busy_q;
  assign pop  = go;

  always_comb begin
    lvl_d = lvl_q;
    unique case (1'b1)
      bus.flush:                   lvl_d = '0;
      push && !pop:                lvl_d = lvl_q + 1'b1;
      pop && !push && !bus.flush:  lvl_d = lvl_q - 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_ISSUE;
      S_ISSUE: state_d = S_SEND;
      S_SEND:
        if (bus.drv_done) begin
          state_d = S_GAP;
          gap_d   = '0;
        end
      S_GAP:
        if (gap_q == GAP_LAST) begin
          state_d = S_BWAIT;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      S_BWAIT: if (!busy_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (push) mem_q[wp_q] <= bus.req_code[{gnt_idx, 3'b000} +: 8];
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      lvl_q   <= '0;
      ack_q   <= '0;
      last_q  <= 2'd3;
      start_q <= 1'b0;
      code_q  <= 8'h00;
      b1_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      lvl_q   <= lvl_d;
      b1_q    <= bus.voice_busy;
      busy_q  <= b1_q;
      start_q <= go;
      ack_q   <= push ? (4'b0001 << gnt_idx) : 4'b0000;
      if (push) last_q <= gnt_idx;
      // Head is latched here, so a same-cycle flush cannot cancel it.
      if (go) code_q <= mem_q[rp_q];
      if (bus.flush) begin
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        if (push) wp_q <= wp_q + 1'b1;
        if (pop)  rp_q <= rp_q + 1'b1;
      end
    end
  end

  assign bus.req_ack    = ack_q;
  assign bus.drv_start  = start_q;
  assign bus.drv_code   = code_q;
  assign bus.fifo_level = lvl_q;
  assign bus.idle       = (state_q == S_IDLE) && (lvl_q == '0);
endmodule
